if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32: PC / address width.
REQ-003 Parameter INST_W, default 32: instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 stall_if  input  1  hold PC; no new fetch accepted.
REQ-007 stall_id  input  1  decode stage holding; IF/ID register keeps contents.
REQ-008 branch_flag  input  1  redirect request from decode, valid for one cycle.
REQ-009 branch_target  input  ADDR_W  redirect address qualified by branch_flag.
REQ-010 flush  input  1  exception/ERET redirect, highest priority.
REQ-011 new_pc  input  ADDR_W  redirect address qualified by flush.
REQ-012 inst_i  input  INST_W  instruction returned combinationally by instruction ROM for pc_o.
REQ-013 pc_o  output  ADDR_W  fetch address to instruction ROM.
REQ-014 ce_o  output  1  ROM chip enable; 1 = fetch valid.
REQ-015 id_pc_o  output  ADDR_W  registered PC presented to decode.
REQ-016 id_inst_o  output  INST_W  registered instruction presented to decode; 0 = bubble (NOP).

Function
REQ-017 FSM states SHALL be IDLE and FETCH; IDLE entered on reset, FETCH entered on first rising edge after rst deasserts, FETCH left only by reset.
REQ-018 ce_o SHALL be 0 in IDLE and 1 in FETCH; pc_o SHALL equal RESET_PC in IDLE.
REQ-019 PC update priority in FETCH, per edge: flush -> new_pc; else branch applied (REQ-021) -> target; else stall_if -> hold; else pc_o + 4 (modulo 2^ADDR_W, 32'hFFFF_FFFC wraps to 0).
REQ-020 flush SHALL take effect on the next edge even when stall_if=1, and SHALL clear any pending branch.
REQ-021 branch_flag with stall_if=0 SHALL load branch_target into PC on that edge; with stall_if=1 SHALL latch target into a one-entry pending register (pend_valid=1).
REQ-022 While pend_valid=1, first edge with stall_if=0 SHALL load the pending target and clear pend_valid; a new branch_flag during pending SHALL overwrite the pending target.
REQ-023 IF/ID register update per edge: flush -> id_pc_o=0, id_inst_o=0; else stall_if=1 and stall_id=0 -> bubble (id_inst_o=0, id_pc_o=0); else stall_id=1 -> hold; else id_pc_o=pc_o, id_inst_o=(ce_o ? inst_i : 0).
REQ-024 Fetch latency: instruction at address A appears on id_inst_o one edge after pc_o=A with no stalls.
REQ-025 Branch delay slot SHALL be preserved: the instruction fetched in the cycle branch_flag is high enters ID normally; no squash on branch.
REQ-026 Misaligned branch_target/new_pc (low 2 bits nonzero) SHALL be loaded unchanged; alignment checking is downstream's job.

Reset
REQ-027 rst=0 SHALL immediately (no clock) force: state IDLE, pc_o=RESET_PC, ce_o=0, pend_valid=0, id_pc_o=0, id_inst_o=0.
REQ-028 Reset mid-operation SHALL discard pending branch and IF/ID contents; fetch restarts at RESET_PC one cycle after release.
REQ-029 Inputs branch_flag, flush, stall_* SHALL be ignored while in IDLE.

Verification
REQ-030 Release reset, no stalls, ROM word[i]=i+1 -> ce_o 0 for one cycle, then pc_o 0,4,8; id_inst_o 1,2,3 on successive edges.
REQ-031 branch_flag=1, branch_target=0x100 at pc_o=0x8 -> next pc_o=0x100; id_pc_o=0x8 (delay slot) then 0x100.
REQ-032 stall_if=1 for 3 cycles with branch_flag pulse to 0x200 in cycle 1 -> pc_o held, id_inst_o=0 bubbles, pc_o=0x200 on first unstalled edge.
REQ-033 stall_if=1, stall_id=1, flush=1, new_pc=0x380 -> pc_o=0x380 next edge, id_inst_o=0, pending cleared.
REQ-034 pc_o=0xFFFF_FFFC, no stall -> next pc_o=0x0.
REQ-035 Assert rst asynchronously between edges during FETCH with pend_valid=1 -> outputs reach reset values before next edge; after release fetch resumes at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction fetch stage that drives the PC, holds one pending
//            branch while fetch is stalled, and feeds the IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_FETCH = 1'b1;

  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] c_PC_STEP  = ADDR_W'(4);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              w_fetch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  state_d = c_FETCH;
      c_FETCH: state_d = c_FETCH;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    w_fetch = (state_q == c_FETCH);
    ce_o    = w_fetch;
    pc_o    = pc_q;
  end

  // Branches arriving during a stall are parked and replayed on the first
  // unstalled edge; flush always wins and drops anything parked.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (w_fetch) begin
      if (flush) begin
        pc_d         = new_pc;
        pend_valid_d = 1'b0;
      end else if (stall_if) begin
        if (branch_flag) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target;
        end
      end else if (branch_flag) begin
        pc_d         = branch_target;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + c_PC_STEP;
      end
    end
  end

  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    if (w_fetch) begin
      if (flush || (stall_if && !stall_id)) begin
        id_pc_d   = '0;
        id_inst_d = '0;
      end else if (!stall_id) begin
        id_pc_d   = pc_q;
        id_inst_d = ce_o ? inst_i : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= c_RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      id_pc_q       <= '0;
      id_inst_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      id_pc_q       <= id_pc_d;
      id_inst_q     <= id_inst_d;
    end
  end

  assign id_pc_o   = id_pc_q;
  assign id_inst_o = id_inst_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed self-checking bench for if_stage; ROM word[i] = i + 1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  int checks;
  int failures;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32),
    .INST_W   (32)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .inst_i        (inst_i),
    .pc_o          (pc_o),
    .ce_o          (ce_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM: word index plus one.
  assign inst_i = {2'b00, pc_o[31:2]} + 32'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_ce,
                              input logic [31:0] e_id_pc, input logic [31:0] e_id_inst);
    check({tag, ".pc"},      pc_o,             e_pc);
    check({tag, ".ce"},      {31'd0, ce_o},    {31'd0, e_ce});
    check({tag, ".id_pc"},   id_pc_o,          e_id_pc);
    check({tag, ".id_inst"}, id_inst_o,        e_id_inst);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    branch_flag   = 1'b0;
    branch_target = '0;
    flush         = 1'b0;
    new_pc        = '0;

    #2;
    expect_state("reset", 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_state("idle", 32'h0, 1'b0, 32'h0, 32'h0);

    // Sequential fetch and latency
    step(); expect_state("fetch0", 32'h0, 1'b1, 32'h0, 32'h0);
    step(); expect_state("fetch1", 32'h4, 1'b1, 32'h0, 32'd1);
    step(); expect_state("fetch2", 32'h8, 1'b1, 32'h4, 32'd2);

    // Branch with delay slot preserved
    branch_flag = 1'b1; branch_target = 32'h100;
    step(); expect_state("br0", 32'h100, 1'b1, 32'h8, 32'd3);
    branch_flag = 1'b0;
    step(); expect_state("br1", 32'h104, 1'b1, 32'h100, 32'd65);

    // Branch during a 3-cycle fetch stall becomes pending
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
    step(); expect_state("stl0", 32'h104, 1'b1, 32'h0, 32'h0);
    branch_flag = 1'b0;
    step(); expect_state("stl1", 32'h104, 1'b1, 32'h0, 32'h0);
    step(); expect_state("stl2", 32'h104, 1'b1, 32'h0, 32'h0);
    stall_if = 1'b0;
    step(); expect_state("stl3", 32'h200, 1'b1, 32'h104, 32'd66);
    step(); expect_state("stl4", 32'h204, 1'b1, 32'h200, 32'd129);

    // Flush overrides both stalls and drops a pending branch
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    step(); expect_state("fl0", 32'h204, 1'b1, 32'h0, 32'h0);
    branch_flag = 1'b0; stall_id = 1'b1; flush = 1'b1; new_pc = 32'h380;
    step(); expect_state("fl1", 32'h380, 1'b1, 32'h0, 32'h0);
    flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
    step(); expect_state("fl2", 32'h384, 1'b1, 32'h380, 32'd225);

    // Decode-only stall holds IF/ID while PC advances
    stall_id = 1'b1;
    step(); expect_state("sid0", 32'h388, 1'b1, 32'h380, 32'd225);
    stall_id = 1'b0;
    step(); expect_state("sid1", 32'h38C, 1'b1, 32'h388, 32'd227);

    // Wrap at top of address space, then misaligned target loaded unchanged
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    step(); expect_state("wrap0", 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0);
    flush = 1'b0;
    step(); expect_state("wrap1", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h4000_0000);
    branch_flag = 1'b1; branch_target = 32'h102;
    step(); expect_state("mis0", 32'h102, 1'b1, 32'h0, 32'd1);
    branch_flag = 1'b0;
    step(); expect_state("mis1", 32'h106, 1'b1, 32'h102, 32'd65);

    // Asynchronous reset while a branch is pending
    stall_if = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
    step(); expect_state("ar0", 32'h106, 1'b1, 32'h0, 32'h0);
    branch_flag = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    expect_state("ar1", 32'h0, 1'b0, 32'h0, 32'h0);
    stall_if = 1'b0;
    step(); expect_state("ar2", 32'h0, 1'b0, 32'h0, 32'h0);

    // Inputs during IDLE are ignored
    @(negedge clk);
    rst = 1'b1; flush = 1'b1; new_pc = 32'h700;
    branch_flag = 1'b1; branch_target = 32'h600; stall_if = 1'b1;
    step(); expect_state("rs0", 32'h0, 1'b1, 32'h0, 32'h0);
    flush = 1'b0; branch_flag = 1'b0; stall_if = 1'b0;
    step(); expect_state("rs1", 32'h4, 1'b1, 32'h0, 32'd1);
    step(); expect_state("rs2", 32'h8, 1'b1, 32'h4, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
